scalar_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the scalar register file. Shares its single write port (regWrEn / regToWrite / dataIn) between several write-back requesters, such as the ALU and the load unit, granting at most one write per cycle. It also keeps a per-register busy scoreboard so the issue stage can reserve a destination register and detect read-after-write hazards. It sits between the execute/memory write-back paths and scalarRegisterFile.

---
 rtl/scalar_ctrl_pkg.sv | 26 ++
 rtl/scalar_wb_rr_arbiter.sv | 59 +++++
 rtl/scalar_wb_arbiter.sv | 90 +++++++++
 tb/tb_scalar_wb_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/scalar_ctrl_pkg.sv
// Shared definitions for the scalar write-back path: requester limits, packed-bus
// slice extraction and the register-file write-port bundle.
package scalar_ctrl_pkg;

    localparam int MAX_REQ   = 4;
    localparam int SLICE_W   = 32;
    localparam int MAX_BUS_W = MAX_REQ * SLICE_W;

    // Write-port bundle sized for the widest supported configuration
    typedef struct packed {
        logic               wrEn;
        logic [7:0]         index;
        logic [SLICE_W-1:0] data;
    } wb_port_t;

    // Returns slice idx of width w (w < SLICE_W) from a zero-extended packed bus
    function automatic logic [SLICE_W-1:0] get_slice(input logic [MAX_BUS_W-1:0] bus,
                                                     input int idx, input int w);
        logic [MAX_BUS_W-1:0] shifted;
        logic [SLICE_W-1:0]   mask;
        shifted = bus >> (idx * w);
        mask    = (SLICE_W'(1) << w) - SLICE_W'(1);
        return shifted[SLICE_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/scalar_wb_rr_arbiter.sv
// Write-back grant logic. RR_ARB_EN selects round-robin with a priority pointer;
// otherwise fixed priority (lowest index wins) with no state.
module scalar_wb_rr_arbiter
    import scalar_ctrl_pkg::*;
#(
    parameter int numReq = 2
) (
`ifdef RR_ARB_EN
    input  logic              clk,
`endif
    input  logic              rst,
    input  logic [numReq-1:0] reqValid,
    output logic [numReq-1:0] grant
);

`ifdef RR_ARB_EN
    localparam int PTR_W = (numReq > 1) ? $clog2(numReq) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    // Search starts at the pointer; the winner's successor becomes the new pointer
    always_comb begin
        logic found;
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        if (!rst) begin
            for (int k = 0; k < numReq; k++) begin
                automatic int idx = (int'(ptr_q) + k) % numReq;
                if (!found && reqValid[idx]) begin
                    grant[idx] = 1'b1;
                    ptr_d      = PTR_W'((idx + 1) % numReq);
                    found      = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        if (!rst) begin
            for (int k = 0; k < numReq; k++) begin
                if (!found && reqValid[k]) begin
                    grant[k] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Scalar register-file write-back arbiter with a busy scoreboard for RAW hazards.
// Arbitration policy is chosen by RR_ARB_EN (round-robin) or fixed priority when undefined.
module scalar_wb_arbiter
    import scalar_ctrl_pkg::*;
#(
    parameter int regSize     = 8,
    parameter int regQuantity = 4,
    parameter int selBits     = 2,
    parameter int numReq      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [numReq-1:0]           reqValid,
    input  logic [numReq*selBits-1:0]   reqReg,
    input  logic [numReq*regSize-1:0]   reqData,
    output logic [numReq-1:0]           reqReady,
    input  logic                        rsvValid,
    input  logic [selBits-1:0]          rsvReg,
    output logic                        rsvReady,
    input  logic [selBits-1:0]          chkSel1,
    input  logic [selBits-1:0]          chkSel2,
    output logic                        chkBusy1,
    output logic                        chkBusy2,
    output logic [regQuantity-1:0]      busyVec,
    output logic                        regWrEn,
    output logic [selBits-1:0]          regToWrite,
    output logic [regSize-1:0]          dataIn
);

    logic [numReq-1:0]      grant;
    logic                   wrEn_q, wrEn_d;
    logic [selBits-1:0]     wrIdx_q, wrIdx_d;
    logic [regSize-1:0]     wrData_q, wrData_d;
    logic [regQuantity-1:0] busy_q, busy_d;

    scalar_wb_rr_arbiter #(.numReq(numReq)) u_arb (
`ifdef RR_ARB_EN
        .clk      (clk),
`endif
        .rst      (rst),
        .reqValid (reqValid),
        .grant    (grant)
    );

    assign reqReady = grant;

    // Write stage: grants only go to valid requesters, so any grant is a handshake
    always_comb begin
        wrEn_d   = |grant;
        wrIdx_d  = wrIdx_q;
        wrData_d = wrData_q;
        for (int i = 0; i < numReq; i++) begin
            if (grant[i]) begin
                wrIdx_d  = selBits'(get_slice(MAX_BUS_W'(reqReg), i, selBits));
                wrData_d = regSize'(get_slice(MAX_BUS_W'(reqData), i, regSize));
            end
        end
    end

    assign rsvReady = ~busy_q[rsvReg];

    // Clear of the written register and set of a reserved one never collide
    always_comb begin
        busy_d = busy_q;
        if (wrEn_q)               busy_d[wrIdx_q] = 1'b0;
        if (rsvValid && rsvReady) busy_d[rsvReg]  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrEn_q   <= 1'b0;
            wrIdx_q  <= '0;
            wrData_q <= '0;
            busy_q   <= '0;
        end else begin
            wrEn_q   <= wrEn_d;
            wrIdx_q  <= wrIdx_d;
            wrData_q <= wrData_d;
            busy_q   <= busy_d;
        end
    end

    assign regWrEn    = wrEn_q;
    assign regToWrite = wrIdx_q;
    assign dataIn     = wrData_q;
    assign busyVec    = busy_q;
    assign chkBusy1   = busy_q[chkSel1];
    assign chkBusy2   = busy_q[chkSel2];

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed bench for scalar_wb_arbiter with a behavioural register file on the write port.
module tb_scalar_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] reqValid;
    logic [3:0] reqReg;
    logic [15:0] reqData;
    logic [1:0] reqReady;
    logic       rsvValid;
    logic [1:0] rsvReg;
    logic       rsvReady;
    logic [1:0] chkSel1, chkSel2;
    logic       chkBusy1, chkBusy2;
    logic [3:0] busyVec;
    logic       regWrEn;
    logic [1:0] regToWrite;
    logic [7:0] dataIn;

    logic [7:0] rf [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scalar_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .reqValid   (reqValid),
        .reqReg     (reqReg),
        .reqData    (reqData),
        .reqReady   (reqReady),
        .rsvValid   (rsvValid),
        .rsvReg     (rsvReg),
        .rsvReady   (rsvReady),
        .chkSel1    (chkSel1),
        .chkSel2    (chkSel2),
        .chkBusy1   (chkBusy1),
        .chkBusy2   (chkBusy2),
        .busyVec    (busyVec),
        .regWrEn    (regWrEn),
        .regToWrite (regToWrite),
        .dataIn     (dataIn)
    );

    // Register file: captures the write port at the end of the cycle regWrEn is high
    always @(posedge clk) begin
        if (regWrEn) rf[regToWrite] <= dataIn;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        rst      = 1'b1;
        reqValid = 2'b11;
        reqReg   = 4'b0;
        reqData  = 16'h0;
        rsvValid = 1'b0;
        rsvReg   = 2'd0;
        chkSel1  = 2'd0;
        chkSel2  = 2'd0;
        tick();
        check("rst_ready", 32'(reqReady), 32'h0);
        check("rst_wren", 32'(regWrEn), 32'h0);
        check("rst_idx", 32'(regToWrite), 32'h0);
        check("rst_data", 32'(dataIn), 32'h0);
        check("rst_busy", 32'(busyVec), 32'h0);
        reqValid = 2'b00;
        rst      = 1'b0;
        #1;

        // Single request: req0 writes reg1 = FE
        reqValid = 2'b01;
        reqReg   = {2'd0, 2'd1};
        reqData  = {8'h00, 8'hFE};
        #1;
        check("single_ready", 32'(reqReady), 32'h1);
        tick();
        reqValid = 2'b00;
        #1;
        check("single_wren", 32'(regWrEn), 32'h1);
        check("single_idx", 32'(regToWrite), 32'h1);
        check("single_data", 32'(dataIn), 32'hFE);
        tick();
        check("single_wren_drop", 32'(regWrEn), 32'h0);
        check("single_data_hold", 32'(dataIn), 32'hFE);
        check("single_rf", 32'(rf[1]), 32'hFE);

        // Contention, req0 drops after its grant
        do_reset();
        reqValid = 2'b11;
        reqReg   = {2'd3, 2'd2};
        reqData  = {8'h22, 8'h11};
        #1;
        check("contA_g0", 32'(reqReady), 32'h1);
        tick();
        reqValid = 2'b10;
        #1;
        check("contA_g1", 32'(reqReady), 32'h2);
        check("contA_idx0", 32'(regToWrite), 32'h2);
        check("contA_data0", 32'(dataIn), 32'h11);
        tick();
        reqValid = 2'b00;
        #1;
        check("contA_wren1", 32'(regWrEn), 32'h1);
        check("contA_idx1", 32'(regToWrite), 32'h3);
        check("contA_data1", 32'(dataIn), 32'h22);
        tick();
        check("contA_rf2", 32'(rf[2]), 32'h11);
        check("contA_rf3", 32'(rf[3]), 32'h22);

        // Contention, both held valid for two cycles
        do_reset();
        reqValid = 2'b11;
        #1;
        check("contB_g0", 32'(reqReady), 32'h1);
        tick();
        check("contB_wren0", 32'(regWrEn), 32'h1);
`ifdef RR_ARB_EN
        check("contB_g1", 32'(reqReady), 32'h2);
`else
        check("contB_g1", 32'(reqReady), 32'h1);
`endif
        tick();
        reqValid = 2'b00;
        #1;
        check("contB_wren1", 32'(regWrEn), 32'h1);
`ifdef RR_ARB_EN
        check("contB_idx1", 32'(regToWrite), 32'h3);
`else
        check("contB_idx1", 32'(regToWrite), 32'h2);
`endif
        tick();

        // Scoreboard: reserve reg3, re-reserve blocked, write clears it
        do_reset();
        rsvValid = 1'b1;
        rsvReg   = 2'd3;
        chkSel1  = 2'd3;
        chkSel2  = 2'd0;
        #1;
        check("rsv_ready", 32'(rsvReady), 32'h1);
        check("rsv_chk_before", 32'(chkBusy1), 32'h0);
        tick();
        check("rsv_again_ready", 32'(rsvReady), 32'h0);
        check("rsv_chk1", 32'(chkBusy1), 32'h1);
        check("rsv_chk2", 32'(chkBusy2), 32'h0);
        check("rsv_busyvec", 32'(busyVec), 32'h8);
        rsvValid = 1'b0;
        reqValid = 2'b10;
        reqReg   = {2'd3, 2'd0};
        reqData  = {8'hFA, 8'h00};
        #1;
        check("sb_ready", 32'(reqReady), 32'h2);
        tick();
        reqValid = 2'b00;
        rsvValid = 1'b1;
        rsvReg   = 2'd1;
        #1;
        check("sb_wren", 32'(regWrEn), 32'h1);
        check("sb_busy_t1", 32'(busyVec), 32'h8);
        check("sim_rsv_ready", 32'(rsvReady), 32'h1);
        tick();
        rsvValid = 1'b0;
        #1;
        check("sim_busyvec", 32'(busyVec), 32'h2);
        check("sb_chk1_clear", 32'(chkBusy1), 32'h0);
        check("sb_rf3", 32'(rf[3]), 32'hFA);

        // Reset asserted while a write to reg2 is pending on the port
        rf[2]    = 8'h00;
        reqValid = 2'b01;
        reqReg   = {2'd0, 2'd2};
        reqData  = {8'h00, 8'h55};
        tick();
        reqValid = 2'b00;
        #1;
        check("mid_wren_pre", 32'(regWrEn), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_wren", 32'(regWrEn), 32'h0);
        check("mid_idx", 32'(regToWrite), 32'h0);
        check("mid_data", 32'(dataIn), 32'h0);
        check("mid_busy", 32'(busyVec), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_rf2", 32'(rf[2]), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
